// File: rtl/perf_pkg.sv
// Shared constants for the performance-counter bank: legacy event line indices,
// counter modes and the index-width helper used for the select ports.
package perf_pkg;

  localparam int EVT_CYCLE        = 0;
  localparam int EVT_JUMP         = 1;
  localparam int EVT_BRANCH       = 2;
  localparam int EVT_BRANCH_TAKEN = 3;
  localparam int EVT_SYSCALL      = 4;
  localparam int EVT_MEM_WR       = 5;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Select-port width; a single-entry space still gets a 1-bit port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Port bundle between the CPU/debug side (master) and the counter bank (slave).
// PERF_SNAPSHOT_EN adds the snapshot strobe, snapshot read select and shadow ovf view.
interface perf_counter_bank_if #(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 16,
  parameter int NUM_EVT = 8
);
  localparam int IDX_W = perf_pkg::idx_w(NUM_CNT);
  localparam int EVT_W = perf_pkg::idx_w(NUM_EVT);

  // No valid/ready pairs: every strobe is single-cycle and level-sampled at
  // the rising edge, and the read port is a plain combinational mux.
  logic [NUM_EVT-1:0] evt;
  logic               halt;
  logic               clear;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [EVT_W-1:0]   cfg_evt;
  logic               cfg_sat;
  logic [IDX_W-1:0]   rd_idx;
  logic [CNT_W-1:0]   rd_data;
  logic [NUM_CNT-1:0] ovf;
  logic               frozen;
`ifdef PERF_SNAPSHOT_EN
  logic               snap;
  logic               rd_snap;
  logic [NUM_CNT-1:0] snap_ovf;
`endif

  modport master (
    output evt, halt, clear, cfg_we, cfg_idx, cfg_evt, cfg_sat, rd_idx,
`ifdef PERF_SNAPSHOT_EN
    output snap, rd_snap,
    input  snap_ovf,
`endif
    input  rd_data, ovf, frozen
  );

  modport slave (
    input  evt, halt, clear, cfg_we, cfg_idx, cfg_evt, cfg_sat, rd_idx,
`ifdef PERF_SNAPSHOT_EN
    input  snap, rd_snap,
    output snap_ovf,
`endif
    output rd_data, ovf, frozen
  );

endinterface

// File: rtl/perf_counter.sv
// One counter channel: event select, wrap/saturate mode, count register and
// sticky overflow flag. Priority inside the channel is clear > cfg write > hit.
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int NUM_EVT = 8,
  parameter int EVT_W   = 3,
  parameter int RST_SEL = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               frozen_i,
  input  logic               cfg_we_i,
  input  logic [EVT_W-1:0]   cfg_evt_i,
  input  logic               cfg_sat_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               ovf_o
);

  localparam int EVT_PAD = 1 << EVT_W;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [EVT_W-1:0]   sel_q, sel_d;
  mode_e              sat_q, sat_d;
  logic [EVT_PAD-1:0] evt_pad;
  logic               hit;

  // Padding lets sel_q index the full power-of-two range without a bounds check.
  assign evt_pad = EVT_PAD'(evt_i);
  assign hit     = evt_pad[sel_q] & ~frozen_i;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    sel_d = sel_q;
    sat_d = sat_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (cfg_we_i) begin
      sel_d = cfg_evt_i;
      sat_d = mode_e'(cfg_sat_i);
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (hit) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (sat_q == MODE_SAT) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      sel_q <= EVT_W'(RST_SEL);
      sat_q <= MODE_WRAP;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      sel_q <= sel_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Programmable performance-counter bank: freeze-on-halt flag, cfg decode, read mux.
// Build option PERF_SNAPSHOT_EN adds a shadow copy of all counters and ovf flags.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 16,
  parameter int NUM_EVT = 8
) (
  input logic                clk,
  input logic                reset,
  perf_counter_bank_if.slave bus
);

  localparam int EVT_W = idx_w(NUM_EVT);

  logic               frozen_q, frozen_d;
  logic               cfg_ok;
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_w;
  logic [CNT_W-1:0]   live_rd;

  // Halt's own cycle still counts because the flag only takes effect next cycle.
  always_comb begin
    frozen_d = frozen_q | bus.halt;
    if (bus.clear) frozen_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) frozen_q <= 1'b0;
    else       frozen_q <= frozen_d;
  end

  assign cfg_ok = bus.cfg_we && (int'(bus.cfg_idx) < NUM_CNT) && (int'(bus.cfg_evt) < NUM_EVT);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_counter #(
      .CNT_W  (CNT_W),
      .NUM_EVT(NUM_EVT),
      .EVT_W  (EVT_W),
      .RST_SEL(i % NUM_EVT)
    ) u_cnt (
      .clk_i    (clk),
      .rst_i    (reset),
      .clr_i    (bus.clear),
      .evt_i    (bus.evt),
      .frozen_i (frozen_q),
      .cfg_we_i (cfg_ok && (int'(bus.cfg_idx) == i)),
      .cfg_evt_i(bus.cfg_evt),
      .cfg_sat_i(bus.cfg_sat),
      .cnt_o    (cnt[i]),
      .ovf_o    (ovf_w[i])
    );
  end

  always_comb begin
    live_rd = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (int'(bus.rd_idx) == i) live_rd = cnt[i];
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0]   shadow_q [NUM_CNT];
  logic [NUM_CNT-1:0] shadow_ovf_q;
  logic [CNT_W-1:0]   snap_rd;

  // Copies register outputs, so the snapshot excludes the snap cycle's hits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= '0;
      shadow_ovf_q <= '0;
    end else if (bus.snap) begin
      for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= cnt[i];
      shadow_ovf_q <= ovf_w;
    end
  end

  always_comb begin
    snap_rd = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (int'(bus.rd_idx) == i) snap_rd = shadow_q[i];
    end
  end

  assign bus.rd_data  = bus.rd_snap ? snap_rd : live_rd;
  assign bus.snap_ovf = shadow_ovf_q;
`else
  assign bus.rd_data = live_rd;
`endif

  assign bus.ovf    = ovf_w;
  assign bus.frozen = frozen_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank with a small 3-counter, 4-bit, 6-event
// configuration so wrap, saturation and out-of-range selects are all reachable.
module tb_perf_counter_bank;
  import perf_pkg::*;

  localparam int NUM_CNT = 3;
  localparam int CNT_W   = 4;
  localparam int NUM_EVT = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [CNT_W-1:0] exp_q[$];
  int               idx_q[$];

  always #5 clk = ~clk;

  perf_counter_bank_if #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .NUM_EVT(NUM_EVT)) bus ();

  perf_counter_bank #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .NUM_EVT(NUM_EVT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.evt    = '0;
    bus.halt   = 1'b0;
    bus.clear  = 1'b0;
    bus.cfg_we = 1'b0;
`ifdef PERF_SNAPSHOT_EN
    bus.snap   = 1'b0;
`endif
  endtask

  task automatic cfg(input int idx, input int evt_sel, input logic sat, input logic [NUM_EVT-1:0] evt_bits);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = 2'(idx);
    bus.cfg_evt = 3'(evt_sel);
    bus.cfg_sat = sat;
    bus.evt     = evt_bits;
    cyc(1);
    idle();
  endtask

  task automatic expect_cnt(input int idx, input logic [CNT_W-1:0] v);
    idx_q.push_back(idx);
    exp_q.push_back(v);
  endtask

  task automatic drain(input string tag);
    int               i;
    logic [CNT_W-1:0] e;
    while (exp_q.size() > 0) begin
      i = idx_q.pop_front();
      e = exp_q.pop_front();
      bus.rd_idx = 2'(i);
      #1;
      chk($sformatf("%s_c%0d", tag, i), 32'(bus.rd_data), 32'(e));
    end
  endtask

  initial begin
    int r;
    int m [NUM_CNT];
    idle();
    bus.cfg_idx = '0;
    bus.cfg_evt = '0;
    bus.cfg_sat = 1'b0;
    bus.rd_idx  = '0;
`ifdef PERF_SNAPSHOT_EN
    bus.rd_snap = 1'b0;
`endif
    reset = 1'b1;
    cyc(2);
    expect_cnt(0, 0); expect_cnt(1, 0); expect_cnt(2, 0);
    drain("reset");
    chk("reset_ovf", 32'(bus.ovf), 0);
    chk("reset_frozen", 32'(bus.frozen), 0);
    reset = 1'b0;

    // Default mapping: cycle and jump lines, then halt (its cycle still counts).
    bus.evt = 6'b000011;
    cyc(10);
    chk("prehalt_frozen", 32'(bus.frozen), 0);
    bus.evt  = 6'b000001;
    bus.halt = 1'b1;
    cyc(1);
    idle();
    chk("halt_frozen", 32'(bus.frozen), 1);
    expect_cnt(0, 11); expect_cnt(1, 10); expect_cnt(2, 0);
    drain("map");
    bus.evt = '1;
    cyc(5);
    idle();
    expect_cnt(0, 11); expect_cnt(1, 10); expect_cnt(2, 0);
    drain("frozen_hold");
    chk("frozen_hold_flag", 32'(bus.frozen), 1);

    // Clear beats halt in the same cycle.
    bus.clear = 1'b1;
    bus.halt  = 1'b1;
    bus.evt   = '1;
    cyc(1);
    idle();
    expect_cnt(0, 0); expect_cnt(1, 0); expect_cnt(2, 0);
    drain("clear");
    chk("clear_frozen", 32'(bus.frozen), 0);
    chk("clear_ovf", 32'(bus.ovf), 0);

    // Wrap: 17 cycle events on a 4-bit counter.
    bus.evt = 6'b000001;
    cyc(17);
    idle();
    expect_cnt(0, 1); expect_cnt(1, 0);
    drain("wrap");
    chk("wrap_ovf", 32'(bus.ovf), 32'b001);
    cfg(0, EVT_CYCLE, MODE_WRAP, 6'b000001);
    expect_cnt(0, 0);
    drain("wrap_cfg");
    chk("wrap_cfg_ovf", 32'(bus.ovf), 0);

    // Saturate: 20 cycle events hold at all-ones.
    cfg(0, EVT_CYCLE, MODE_SAT, '0);
    bus.evt = 6'b000001;
    cyc(20);
    idle();
    expect_cnt(0, 15); expect_cnt(1, 0);
    drain("sat");
    chk("sat_ovf", 32'(bus.ovf), 32'b001);

    // cfg write collides with counter 2's own event: the hit is dropped.
    bus.evt = 6'b000100;
    cyc(3);
    idle();
    expect_cnt(2, 3);
    drain("pre_coll");
    cfg(2, EVT_BRANCH, MODE_WRAP, 6'b000100);
    expect_cnt(2, 0);
    drain("coll");
    bus.evt = 6'b000100;
    cyc(1);
    idle();
    expect_cnt(2, 1);
    drain("post_coll");

    // Out-of-range cfg index / event and read index.
    cfg(NUM_CNT, EVT_CYCLE, MODE_WRAP, '0);
    expect_cnt(0, 15); expect_cnt(1, 0); expect_cnt(2, 1);
    drain("bad_idx");
    chk("bad_idx_ovf", 32'(bus.ovf), 32'b001);
    cfg(0, NUM_EVT, MODE_WRAP, '0);
    expect_cnt(0, 15);
    drain("bad_evt");
    chk("bad_evt_ovf", 32'(bus.ovf), 32'b001);
    bus.rd_idx = 2'(NUM_CNT);
    #1;
    chk("bad_rd", 32'(bus.rd_data), 0);

    // Random event traffic on remapped, saturating counters.
    bus.clear = 1'b1;
    cyc(1);
    idle();
    cfg(0, EVT_JUMP, MODE_SAT, '0);
    cfg(1, EVT_BRANCH_TAKEN, MODE_SAT, '0);
    cfg(2, EVT_MEM_WR, MODE_SAT, '0);
    for (int k = 0; k < NUM_CNT; k++) m[k] = 0;
    for (int n = 0; n < 12; n++) begin
      r = $urandom_range(0, 63);
      bus.evt = 6'(r);
      cyc(1);
      if (r[EVT_JUMP] && m[0] < 15) m[0]++;
      if (r[EVT_BRANCH_TAKEN] && m[1] < 15) m[1]++;
      if (r[EVT_MEM_WR] && m[2] < 15) m[2]++;
    end
    idle();
    for (int k = 0; k < NUM_CNT; k++) expect_cnt(k, 4'(m[k]));
    drain("rand");

`ifdef PERF_SNAPSHOT_EN
    bus.clear = 1'b1;
    cyc(1);
    idle();
    cfg(0, EVT_CYCLE, MODE_WRAP, '0);
    bus.evt = 6'b000001;
    cyc(5);
    bus.snap = 1'b1;
    cyc(1);
    bus.snap = 1'b0;
    cyc(2);
    idle();
    bus.rd_idx  = '0;
    bus.rd_snap = 1'b1;
    #1;
    chk("snap_shadow", 32'(bus.rd_data), 5);
    bus.rd_snap = 1'b0;
    #1;
    chk("snap_live", 32'(bus.rd_data), 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
